// File: rtl/pc_seq_pkg.sv
// Shared definitions for the next-PC sequencer: state/source encodings and default vectors.
package pc_seq_pkg;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_PEND = 3'd2,
    SRC_EXC  = 3'd3,
    SRC_ERET = 3'd4
  } src_e;

  localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
  localparam logic [31:0] PC_HANDLER_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEF    = 32'h0000_3000;
  localparam logic [31:0] IM_END_DEF     = 32'h0000_6FFF;
  localparam logic [4:0]  EXC_ADEL       = 5'd4;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_seq_adel_chk.sv
// Fetch address error check: misaligned PC or PC outside the instruction memory window.
module pc_adel_chk
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] IM_BASE = IM_BASE_DEF,
  parameter logic [31:0] IM_END  = IM_END_DEF
) (
  input  logic [31:0] pc_i,
  output logic        adel_o
);

  assign adel_o = (pc_i[1:0] != 2'b00) | (pc_i < IM_BASE) | (pc_i > IM_END);

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection for the F-stage PC register; buffers a branch redirect across a stall.
// Optional fetch address error check enabled by defining PC_SEQ_ADEL_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = PC_RESET_DEF,
  parameter logic [31:0] HANDLER_PC = PC_HANDLER_DEF,
  parameter logic [31:0] IM_BASE    = IM_BASE_DEF,
  parameter logic [31:0] IM_END     = IM_END_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        br_valid_i,
  input  logic [31:0] br_target_i,
  input  logic        exc_req_i,
  input  logic        eret_req_i,
  input  logic [31:0] epc_i,
  output logic [31:0] npc_o,
  output logic        pc_we_o,
  output logic        flush_o,
  output logic        pend_o,
  output logic [15:0] redir_cnt_o,
  output logic        fetch_adel_o
);

  state_e      state_q, state_d;
  logic [31:0] pend_q, pend_d;
  logic [15:0] cnt_q;
  src_e        src;
  logic        we;

  if (IM_BASE > IM_END) begin : g_bad_range
    $error("pc_sequencer: IM_BASE above IM_END");
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    npc_o   = pc_i + 32'd4;
    we      = ~stall_i;
    flush_o = 1'b0;
    src     = SRC_SEQ;
    if (reset) begin
      npc_o   = RESET_PC;
      we      = 1'b0;
      state_d = IDLE;
    end else if (exc_req_i) begin
      npc_o   = HANDLER_PC;
      we      = 1'b1;
      flush_o = 1'b1;
      src     = SRC_EXC;
      state_d = IDLE;
    end else if (eret_req_i) begin
      npc_o   = epc_i;
      we      = 1'b1;
      flush_o = 1'b1;
      src     = SRC_ERET;
      state_d = IDLE;
    end else if (state_q == HOLD) begin
      // a branch arriving while held replaces the buffered one
      if (stall_i) begin
        we = 1'b0;
        if (br_valid_i) pend_d = br_target_i;
      end else begin
        npc_o   = br_valid_i ? br_target_i : pend_q;
        we      = 1'b1;
        src     = br_valid_i ? SRC_BR : SRC_PEND;
        state_d = IDLE;
      end
    end else if (br_valid_i) begin
      if (stall_i) begin
        we      = 1'b0;
        pend_d  = br_target_i;
        state_d = HOLD;
      end else begin
        npc_o = br_target_i;
        we    = 1'b1;
        src   = SRC_BR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      if (we && src != SRC_SEQ) cnt_q <= sat_inc16(cnt_q);
    end
  end

  assign pc_we_o     = we;
  assign pend_o      = (state_q == HOLD);
  assign redir_cnt_o = cnt_q;

`ifdef PC_SEQ_ADEL_EN
  logic adel;

  pc_adel_chk #(.IM_BASE(IM_BASE), .IM_END(IM_END)) u_adel (
    .pc_i   (pc_i),
    .adel_o (adel)
  );

  assign fetch_adel_o = adel & ~reset;
`else
  assign fetch_adel_o = 1'b0;
`endif

endmodule
